// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default frame geometry and the frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BITS  = 2'd2
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int PARITY_EN_DEF  = 1;

  // Bits strobed after the start bit: data, optional parity, stop.
  function automatic int frame_bits(input int data_bits, input int parity_en);
    return data_bits + parity_en + 1;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle
// (high) level so a reset never looks like a falling edge.
module uart_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: start-bit validation and per-bit strobes using a
// 3-sample majority vote on the oversampling tick.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int PARITY_EN  = PARITY_EN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic rx,
  input  logic abort,
  output logic start_bit_dec,
  output logic bit_strobe,
  output logic bit_val,
  output logic bit_last,
  output logic false_start,
  output logic busy
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN);
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int IDX_W      = $clog2(FRAME_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_BITS - 1);

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  logic              rx_s;
  rx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              armed_q, armed_d;
  logic [2:0]        samp_q, samp_d;
  logic              maj;
  logic              mid_hit, end_hit;
  logic              sbd_q, sbd_d;
  logic              fs_q, fs_d;
  logic              strobe_q, strobe_d;
  logic              last_q, last_d;
  logic              val_q, val_d;
  logic              busy_q, busy_d;

  uart_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      armed_q  <= 1'b0;
      samp_q   <= 3'b111;
      sbd_q    <= 1'b0;
      fs_q     <= 1'b0;
      strobe_q <= 1'b0;
      last_q   <= 1'b0;
      val_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      armed_q  <= armed_d;
      samp_q   <= samp_d;
      sbd_q    <= sbd_d;
      fs_q     <= fs_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
      val_q    <= val_d;
      busy_q   <= busy_d;
    end
  end

  // The vote always uses the history including this tick's sample.
  assign maj = maj3(samp_d);

  always_comb begin : next_state
    samp_d  = baud_tick ? {samp_q[1:0], rx_s} : samp_q;
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    case (state_q)
      ST_IDLE: begin
        if (baud_tick) begin
          if (armed_q && !rx_s) begin
            state_d = ST_START;
            tick_d  = '0;
            armed_d = 1'b0;
          end else if (rx_s) begin
            armed_d = 1'b1;
          end
        end
      end
      ST_START: begin
        if (baud_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            idx_d   = '0;
            state_d = maj ? ST_IDLE : ST_BITS;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_BITS: begin
        if (baud_tick) begin
          if (tick_q == TICK_END) begin
            tick_d = '0;
            idx_d  = idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Abort takes priority over any pulse decided on the same edge.
  always_comb begin : output_next
    mid_hit  = baud_tick && (state_q == ST_START) && (tick_q == TICK_MID);
    end_hit  = baud_tick && (state_q == ST_BITS) && (tick_q == TICK_END);
    sbd_d    = mid_hit && !maj && !abort;
    fs_d     = mid_hit && maj && !abort;
    strobe_d = end_hit && !abort;
    last_d   = strobe_d && (idx_q == IDX_LAST);
    val_d    = strobe_d ? maj : val_q;
    busy_d   = (state_d != ST_IDLE);
  end

  assign start_bit_dec = sbd_q;
  assign false_start   = fs_q;
  assign bit_strobe    = strobe_q;
  assign bit_last      = last_q;
  assign bit_val       = val_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed and randomized frames against a
// per-cycle expectation table built from the frame contents.
module tb_uart_rx_sampler;

  localparam int OS   = 16;
  localparam int NB   = 10;             // 8 data + parity + stop
  localparam int MAXC = 32768;
  localparam int DET  = 3;              // 2 sync stages + the tick that sees the edge
  localparam int MIDC = DET + OS / 2;   // start-bit decision cycle after the falling edge

  logic clk = 1'b0;
  logic rst, baud_tick, rx, abort;
  logic start_bit_dec, bit_strobe, bit_val, bit_last, false_start, busy;

  uart_rx_sampler #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rx            (rx),
    .abort         (abort),
    .start_bit_dec (start_bit_dec),
    .bit_strobe    (bit_strobe),
    .bit_val       (bit_val),
    .bit_last      (bit_last),
    .false_start   (false_start),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  bit exp_sbd  [MAXC];
  bit exp_fs   [MAXC];
  bit exp_str  [MAXC];
  bit exp_last [MAXC];
  bit exp_val  [MAXC];
  bit exp_busy [MAXC];
  logic bv_m = 1'b0;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sbd"},    start_bit_dec, 1'b0);
    chk({tag, "_fs"},     false_start,   1'b0);
    chk({tag, "_strobe"}, bit_strobe,    1'b0);
    chk({tag, "_last"},   bit_last,      1'b0);
    chk({tag, "_val"},    bit_val,       1'b0);
    chk({tag, "_busy"},   busy,          1'b0);
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      bv_m = 1'b0;
    end else if (cyc < MAXC) begin
      if (exp_str[cyc]) bv_m = exp_val[cyc];
      chk("start_bit_dec", start_bit_dec, exp_sbd[cyc]);
      chk("false_start",   false_start,   exp_fs[cyc]);
      chk("bit_strobe",    bit_strobe,    exp_str[cyc]);
      chk("bit_last",      bit_last,      exp_last[cyc]);
      chk("bit_val",       bit_val,       bv_m);
      chk("busy",          busy,          exp_busy[cyc]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
    return {1'b1, ^d, d};
  endfunction

  // Strobed bits appear one bit period apart, starting one period after the
  // start-bit decision; n_str strobes precede an abort (NB when none).
  task automatic set_exp(input int p, input logic [NB-1:0] bits, input int abort_idx);
    int n_str = (abort_idx >= 0) ? abort_idx : NB;
    int e_end = (abort_idx >= 0) ? p + MIDC + OS * (abort_idx + 1) : p + MIDC + OS * NB;
    exp_sbd[p + MIDC] = 1'b1;
    for (int i = 0; i < n_str; i++) begin
      exp_str[p + MIDC + OS * (i + 1)]  = 1'b1;
      exp_val[p + MIDC + OS * (i + 1)]  = bits[i];
      exp_last[p + MIDC + OS * (i + 1)] = (i == NB - 1);
    end
    for (int c = p + DET; c < e_end; c++) exp_busy[c] = 1'b1;
  endtask

  task automatic do_reset();
    for (int c = cyc; c < cyc + 400; c++) begin
      exp_sbd[c] = 0; exp_fs[c] = 0; exp_str[c] = 0;
      exp_last[c] = 0; exp_val[c] = 0; exp_busy[c] = 0;
    end
    rst   = 1'b1;
    rx    = 1'b1;
    abort = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    repeat (3) step();
    rst = 1'b0;
  endtask

  // gbit indexes the line including the start bit (1..8 = data bits).
  task automatic send_frame(input logic [7:0] d, input int gbit, input int goff,
                            input int abort_idx, input int rst_at);
    logic [NB-1:0] bits = frame_of(d);
    logic [NB:0]   line = {bits, 1'b0};
    int p = cyc;
    int a_edge = (abort_idx >= 0) ? MIDC + OS * (abort_idx + 1) : -1;
    set_exp(p, bits, abort_idx);
    for (int t = 0; t < (NB + 1) * OS; t++) begin
      if (t == rst_at) begin
        do_reset();
        return;
      end
      if (a_edge >= 0 && t >= a_edge) begin
        rx = 1'b1;
      end else begin
        rx = line[t / OS];
        if (gbit >= 0 && t == gbit * OS + goff) rx = ~rx;
      end
      abort = (t == a_edge - 1);
      step();
    end
    abort = 1'b0;
    rx    = 1'b1;
  endtask

  task automatic send_short_low(input int n);
    int p = cyc;
    exp_fs[p + MIDC] = 1'b1;
    for (int c = p + DET; c < p + MIDC; c++) exp_busy[c] = 1'b1;
    rx = 1'b0;
    repeat (n) step();
    rx = 1'b1;
  endtask

  task automatic send_break(input int n);
    set_exp(cyc, '0, -1);
    rx = 1'b0;
    repeat (n) step();
    rx = 1'b1;
  endtask

  // Idle line with one abort pulse, which must be ignored in IDLE.
  task automatic gap(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) begin
      abort = (i == n - 5);
      step();
    end
    abort = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, gb;
    rst       = 1'b1;
    baud_tick = 1'b1;
    rx        = 1'b1;
    abort     = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    gap(40);

    send_frame(8'hA5, -1, 0, -1, -1);
    gap(30);
    send_short_low(4);
    gap(30);
    send_frame(8'hA5, 4, 8, -1, -1);
    gap(30);
    send_frame(8'h5A, -1, 0, 4, -1);
    gap(30);
    send_frame(8'h3C, -1, 0, -1, -1);
    gap(30);
    send_break(300);
    gap(30);
    send_frame(8'h3C, -1, 0, -1, -1);
    gap(30);
    send_frame(8'hFF, -1, 0, -1, 56);
    gap(30);
    send_frame(8'hFF, -1, 0, -1, -1);
    gap(30);

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_short_low($urandom_range(1, 5));
      end else begin
        gb = (r % 2 == 1) ? $urandom_range(1, 8) : -1;
        send_frame(8'($urandom_range(0, 255)), gb, $urandom_range(0, 15),
                   (r == 8) ? $urandom_range(0, 9) : -1, -1);
      end
      gap($urandom_range(20, 60));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Receive front end of the UART. Sits directly upstream of the receive control FSM and the receive shift register.
- Synchronises the asynchronous rx line and validates the start bit at mid-bit using 3-sample majority voting on a 16x oversampling tick.
- Produces `start_bit_dec`, then one `bit_strobe` per data/parity/stop bit, each carrying the voted bit value, paced at the bit centre.

Parameters:
- OVERSAMPLE, 16, `baud_tick` pulses per bit period. Even, >= 4.
- DATA_BITS, 8, data bits per frame.
- PARITY_EN, 1, 1 = one parity bit follows the data bits; 0 = none.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- baud_tick  input  1  single-cycle enable at OVERSAMPLE x baud rate.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- abort  input  1  downstream request to drop the current frame (e.g. parity error).
- start_bit_dec  output  1  one-cycle pulse: start bit validated.
- bit_strobe  output  1  one-cycle pulse: `bit_val` holds a new frame bit.
- bit_val  output  1  voted value of the bit just strobed.
- bit_last  output  1  high with the `bit_strobe` of the stop bit.
- false_start  output  1  one-cycle pulse: start bit rejected as a glitch.
- busy  output  1  high from start detection until the frame ends or is aborted.

Behaviour:
- **Reset.** Reset is asynchronous, active-high; one clock `clk`. On reset:
  - state = IDLE; all outputs = 0.
  - Synchroniser and sample history = 1 (idle line).
  - tick_cnt = 0, bit_idx = 0, armed = 0.
- **Synchroniser.** 2-FF: `rx_s` lags `rx` by 2 clk.
- **Sample history.** `samp[2:0]` shifts in `rx_s` on every `baud_tick`, in all states. `maj` = 2-of-3 majority of `samp`.
- **armed flag.** Set on any `baud_tick` with `rx_s`=1 in IDLE. Cleared on leaving IDLE. Prevents retrigger on a held-low (break) line.
- **Output registration.** All outputs are registered and assert 1 cycle after the deciding `baud_tick` edge.
- **FRAME_BITS** = DATA_BITS + PARITY_EN + 1 (stop bit).
- **State IDLE** (`busy`=0):
  - On `baud_tick` with `armed`=1 and `rx_s`=0: tick_cnt <= 0, go to START.
- **State START** (`busy`=1):
  - tick_cnt increments on each `baud_tick`.
  - On the `baud_tick` where tick_cnt == OVERSAMPLE/2 - 1 (mid-bit), evaluate `maj` after this tick's shift:
    - `maj`=0: pulse `start_bit_dec`; tick_cnt <= 0, bit_idx <= 0; go to BITS.
    - `maj`=1: pulse `false_start`; go to IDLE.
- **State BITS** (`busy`=1):
  - tick_cnt increments on each `baud_tick`.
  - On the `baud_tick` where tick_cnt == OVERSAMPLE-1:
    - pulse `bit_strobe` with `bit_val` = `maj`;
    - tick_cnt <= 0, bit_idx <= bit_idx + 1.
  - When bit_idx == FRAME_BITS-1 at that strobe: `bit_last`=1 with the strobe, then go to IDLE.
- **bit_val hold.** `bit_val` holds its value between strobes.
- **Bit order.** Strobe order is data LSB first, then parity (if enabled), then stop. The sampler does not check the stop value; it is passed through `bit_val`.
- **abort.**
  - Any cycle in START/BITS: next state IDLE, `busy` low next cycle.
  - A `bit_strobe`/`bit_last`/`start_bit_dec` due in the same cycle is suppressed; abort wins.
  - In IDLE, `abort` has no effect.
- **Mid-operation reset.** Immediate return to reset values; no pulse is emitted.
- **Missing ticks.** `baud_tick` absent: all counters freeze; no timeout.
- **Counter widths.**
  - tick_cnt: $clog2(OVERSAMPLE) bits; never wraps, explicitly cleared.
  - bit_idx: $clog2(FRAME_BITS+1) bits.

Decomposition:
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, BITS);
  - defaults for OVERSAMPLE, DATA_BITS, PARITY_EN;
  - FRAME_BITS function.
- One natural sub-module, `uart_sync_2ff`: the 2-FF synchroniser with reset value 1. The majority vote and FSM stay in this module.

Test Plan:
Common setup for all scenarios: OVERSAMPLE=16, DATA_BITS=8, PARITY_EN=1, `baud_tick` tied to 1 (bit = 16 clk), rx idle high for 40 clk first.
- Valid frame 0xA5, even parity 0, stop 1:
  - `start_bit_dec` once.
  - 10 `bit_strobe`s spaced 16 clk, `bit_val` = 1,0,1,0,0,1,0,1,0,1.
  - `bit_last` on the 10th strobe only; `busy` low 1 clk later.
- rx low for 4 clk only, then high -> `false_start` pulse about 10 clk after the falling edge; no `start_bit_dec`, no strobes; `busy` back to 0.
- Single-clk high glitch at the centre of data bit 3 (value 0) -> `bit_val`=0 at strobe 4 (majority rejects the glitch).
- `abort` asserted 1 clk in the same cycle as strobe 5 -> strobe 5 suppressed, `busy`=0 next cycle, no further strobes; the next frame 0x3C is received correctly.
- rx held low 300 clk (break) -> exactly one frame attempt ends with `bit_last`, `bit_val`=0. No new `start_bit_dec` until rx returns high for at least one tick and then falls.
- `rst` pulsed during data bit 2 -> all outputs 0 asynchronously; after release with rx high, frame 0xFF is received with 10 correct strobes.
